mips_fetch_unit: RTL and testbench
==================================

# mips_fetch_unit

Instruction fetch and PC sequencer for the MIPS32 single-issue core. It issues word reads to instruction memory over a request/ready handshake and presents the fetched instruction, with `opc` and `func` split out, to the control unit. It then waits for the control unit's branch, jump and invalid-opcode verdict to compute the next PC. It is the producer of the instruction stream the control unit decodes, and the consumer of the control unit's control-flow outputs.

## Interface
- `RESET_PC`, default 32'h0040_0000: first fetch address; bits [1:0] must be 0.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  32  word address of the request; equals `pc`.
- `imem_ready`  in  1  memory has valid `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `inst_valid`  out  1  `inst` / `opc` / `func` are valid and awaiting `inst_ack`.
- `inst`  out  32  latched instruction.
- `opc`  out  6  `inst[31:26]`.
- `func`  out  6  `inst[5:0]`.
- `pc`  out  32  address of the current instruction.
- `pc_plus4`  out  32  `pc + 4`, modulo 2^32.
- `inst_ack`  in  1  control unit and execute have consumed `inst`; the verdict inputs are valid this cycle.
- `isJmp`, `isBeq`, `isBne`  in  1  control-flow verdict from the control unit.
- `aluZero`  in  1  ALU zero flag for the current instruction.
- `invOpcode`  in  1  current instruction is invalid.
- `trap`  out  1  fetch halted on an invalid instruction.
- `retired`  out  32  count of acknowledged valid instructions.

## Operation
- The FSM has four states: IDLE, FETCH, HOLD and HALT. The reset state is IDLE.
- **IDLE:**
  - Transitions to FETCH unconditionally on the next cycle.
- **FETCH:**
  - `imem_req` is high and `imem_addr` equals `pc`; both are held stable until `imem_ready` is sampled high.
  - On the edge where `imem_ready` is high: capture `imem_rdata` into `inst` and go to HOLD.
- **HOLD:**
  - `inst_valid` is high; `inst` and `pc` are held stable.
  - On the edge where `inst_ack` is high and `invOpcode` is 1: go to HALT. `pc` and `retired` are not updated.
  - On the edge where `inst_ack` is high and `invOpcode` is 0: increment `retired`, load the next PC into `pc`, and go to FETCH.
- **HALT:**
  - `trap` is 1; `imem_req` and `inst_valid` are 0.
  - Only `rst_n` leaves this state.
- **Next-PC rules (priority order):**
  - If `isJmp`: next PC = `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  - Else if `(isBeq & aluZero) | (isBne & ~aluZero)`: next PC = `pc_plus4 + {{14{inst[15]}}, inst[15:0], 2'b00}`, truncated to 32 bits.
  - Else: next PC = `pc_plus4`.
- **Arithmetic:** all PC arithmetic is 32-bit and wraps silently; `pc[1:0]` is always 00. `retired` wraps from 32'hFFFF_FFFF to 0.
- **Ignored inputs:**
  - `imem_ready` is ignored outside FETCH.
  - `inst_ack` and the verdict inputs are ignored outside HOLD.
  - `isBeq` and `isBne` asserted together follow the OR expression above.

## Timing
- **Reset values:**
  - `pc` = `RESET_PC`, `inst` = 0, `retired` = 0.
  - `imem_req`, `inst_valid` and `trap` are 0.
  - `opc`, `func` and `pc_plus4` follow from these.
- **Asynchronous reset:** assertion forces the reset values immediately in any state, including mid-FETCH with a request outstanding. Fetch restarts from `RESET_PC`. A late `imem_ready` arriving during IDLE is ignored.
- **First request:** `imem_req` rises in the second cycle after `rst_n` deasserts (one IDLE cycle).
- **Output decode:** `imem_req`, `inst_valid` and `trap` are decoded from the registered state, so they are glitch-free.
- **FETCH latency:** one cycle when `imem_ready` is high in the cycle `imem_req` is high. Each wait cycle adds one cycle.
- **HOLD latency:** at least one cycle; `inst_ack` is accepted on the first HOLD edge.
- **Throughput:** best case is one instruction per 2 cycles. The new `pc` drives `imem_addr` in the FETCH cycle immediately after the ack edge.

## Test plan
- **Reset and sequential fetch:** release `rst_n`; memory is zero-wait and returns `add` words; ack each in its first HOLD cycle. Required: `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008, each 2 cycles apart; `retired` = 3.
- **Wait states:** hold `imem_ready` low for 3 cycles. Required: `imem_req` and `imem_addr` stable for 4 cycles; `inst_valid` rises on the cycle after `ready`.
- **BEQ:** at `pc` = 0x00400010 with `inst[15:0]` = 16'hFFFC.
  - `isBeq` = 1, `aluZero` = 1: next PC = 0x00400004.
  - `aluZero` = 0: next PC = 0x00400014.
  - Repeat with `isBne` for the inverse result.
- **Jump and wrap:**
  - `j` with target field 26'h0000100 at `pc` 0x00400020: next PC = 0x00000400.
  - `pc` = 0xFFFFFFFC with no branch: next PC = 0x00000000.
- **Invalid opcode:** ack with `invOpcode` = 1. Required: `trap` = 1 next cycle, no further `imem_req`, `retired` unchanged; held until reset.
- **Reset mid-fetch:** assert `rst_n` = 0 during FETCH wait. Required: `imem_req` drops immediately; after release, the first request is at `RESET_PC`.

Source files
------------

// File: rtl/mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// mips_fetch_unit
//
// Instruction fetch and PC sequencer for the MIPS32 single-issue core.
// Issues word reads to instruction memory, latches the returned instruction
// and holds it (with opc/func split out) until the control unit acknowledges
// it. The control-flow verdict given with the acknowledge selects the next PC.
// An invalid-opcode verdict halts fetch until reset.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  instruction read request and word address (= pc)
//   imem_ready/rdata    memory response valid and instruction word
//   inst_valid          inst/opc/func valid, awaiting inst_ack
//   inst, opc, func     latched instruction and its opcode/function fields
//   pc, pc_plus4        current instruction address and its successor
//   inst_ack            instruction consumed; verdict inputs valid
//   isJmp/isBeq/isBne   control-flow verdict from the control unit
//   aluZero             ALU zero flag for the current instruction
//   invOpcode           current instruction is invalid
//   trap                fetch halted on an invalid instruction
//   retired             count of acknowledged valid instructions
// ---------------------------------------------------------------------------
module mips_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  opc,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        inst_ack,
  input  logic        isJmp,
  input  logic        isBeq,
  input  logic        isBne,
  input  logic        aluZero,
  input  logic        invOpcode,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

  fetchState_t state;

  logic        brTaken;
  logic [31:0] brOffset;
  logic [31:0] jmpTarget;
  logic [31:0] nextPc;

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign opc       = inst[31:26];
  assign func      = inst[5:0];

  // Next-PC selection: jump has priority over a taken branch, else fall through.
  always_comb begin
    brTaken   = (isBeq & aluZero) | (isBne & ~aluZero);
    brOffset  = {{14{inst[15]}}, inst[15:0], 2'b00};
    jmpTarget = {pc_plus4[31:28], inst[25:0], 2'b00};
    if (isJmp) begin
      nextPc = jmpTarget;
    end else if (brTaken) begin
      nextPc = pc_plus4 + brOffset;
    end else begin
      nextPc = pc_plus4;
    end
  end

  // Fetch FSM; imem_req/inst_valid/trap are flops updated together with the
  // state so they are a glitch-free function of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      retired    <= 32'd0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      trap       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            state      <= HOLD;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (inst_ack) begin
            inst_valid <= 1'b0;
            if (invOpcode) begin
              // pc and retired stay on the offending instruction
              state <= HALT;
              trap  <= 1'b1;
            end else begin
              retired  <= retired + 32'd1;
              pc       <= nextPc;
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state      <= IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
          trap       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_fetch_unit
//
// Directed bench for mips_fetch_unit. A table of instructions is executed in
// program order; each record gives the instruction word, the verdict driven
// with its acknowledge, memory wait states, extra HOLD cycles, the address it
// must be fetched from and the PC that must follow. Reset, invalid-opcode
// halt and reset-during-fetch are covered by hand-written sequences.
// ---------------------------------------------------------------------------
module tb_mips_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] ADD_W    = 32'h012A_4020; // add $t0,$t1,$t2
  localparam int          NVEC     = 15;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [5:0]  opc;
  logic [5:0]  func;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        inst_ack;
  logic        isJmp;
  logic        isBeq;
  logic        isBne;
  logic        aluZero;
  logic        invOpcode;
  logic        trap;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instWord;
    logic        jmp;
    logic        beq;
    logic        bne;
    logic        zero;
    int          waits;
    int          ackDelay;
    logic [31:0] addr;
    logic [31:0] next;
  } vec_t;

  vec_t vecs [NVEC];

  mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .opc        (opc),
    .func       (func),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .inst_ack   (inst_ack),
    .isJmp      (isJmp),
    .isBeq      (isBeq),
    .isBne      (isBne),
    .aluZero    (aluZero),
    .invOpcode  (invOpcode),
    .trap       (trap),
    .retired    (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearVerdict();
    inst_ack  = 1'b0;
    isJmp     = 1'b0;
    isBeq     = 1'b0;
    isBne     = 1'b0;
    aluZero   = 1'b0;
    invOpcode = 1'b0;
  endtask

  // Runs one table record starting at a negedge in FETCH; ends at the
  // negedge after the acknowledge edge.
  task automatic doStep(input int i);
    vec_t        v;
    logic [31:0] e4;
    v  = vecs[i];
    e4 = v.addr + 32'd4;
    chk($sformatf("v%0d req", i), {31'd0, imem_req}, 32'd1);
    chk($sformatf("v%0d addr", i), imem_addr, v.addr);
    // wait states; ack/verdict noise must be ignored in FETCH
    for (int w = 0; w < v.waits; w++) begin
      imem_ready = 1'b0;
      inst_ack   = 1'b1;
      isJmp      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d wait%0d req", i, w), {31'd0, imem_req}, 32'd1);
      chk($sformatf("v%0d wait%0d addr", i, w), imem_addr, v.addr);
      chk($sformatf("v%0d wait%0d valid", i, w), {31'd0, inst_valid}, 32'd0);
    end
    clearVerdict();
    imem_ready = 1'b1;
    imem_rdata = v.instWord;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk($sformatf("v%0d valid", i), {31'd0, inst_valid}, 32'd1);
    chk($sformatf("v%0d inst", i), inst, v.instWord);
    chk($sformatf("v%0d opc", i), {26'd0, opc}, {26'd0, v.instWord[31:26]});
    chk($sformatf("v%0d func", i), {26'd0, func}, {26'd0, v.instWord[5:0]});
    chk($sformatf("v%0d pc", i), pc, v.addr);
    chk($sformatf("v%0d pc_plus4", i), pc_plus4, e4);
    chk($sformatf("v%0d req_hold", i), {31'd0, imem_req}, 32'd0);
    // extra HOLD cycles; a stray ready must not overwrite inst
    for (int d = 0; d < v.ackDelay; d++) begin
      imem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d hold%0d valid", i, d), {31'd0, inst_valid}, 32'd1);
      chk($sformatf("v%0d hold%0d inst", i, d), inst, v.instWord);
      chk($sformatf("v%0d hold%0d pc", i, d), pc, v.addr);
    end
    imem_ready = 1'b0;
    inst_ack   = 1'b1;
    isJmp      = v.jmp;
    isBeq      = v.beq;
    isBne      = v.bne;
    aluZero    = v.zero;
    @(posedge clk);
    @(negedge clk);
    clearVerdict();
    chk($sformatf("v%0d valid_after", i), {31'd0, inst_valid}, 32'd0);
    chk($sformatf("v%0d next_pc", i), pc, v.next);
    chk($sformatf("v%0d retired", i), retired, 32'(i + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //          inst           jmp   beq   bne   zero  w  d  addr           next
    vecs[0]  = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0040_0000, 32'h0040_0004};
    vecs[1]  = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 3, 0, 32'h0040_0004, 32'h0040_0008};
    vecs[2]  = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 0, 2, 32'h0040_0008, 32'h0040_000C};
    vecs[3]  = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0040_000C, 32'h0040_0010};
    vecs[4]  = '{32'h1109_FFFC, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0040_0010, 32'h0040_0004};
    vecs[5]  = '{32'h1109_0002, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0040_0004, 32'h0040_0010};
    vecs[6]  = '{32'h1109_FFFC, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0040_0010, 32'h0040_0014};
    vecs[7]  = '{32'h1509_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0040_0014, 32'h0040_0010};
    vecs[8]  = '{32'h1509_FFFC, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0040_0010, 32'h0040_0014};
    vecs[9]  = '{32'h1509_FFFC, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0040_0014, 32'h0040_0008};
    vecs[10] = '{32'h1109_0005, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 32'h0040_0008, 32'h0040_0020};
    vecs[11] = '{32'h0800_0100, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0040_0020, 32'h0000_0400};
    vecs[12] = '{32'h1109_FEFE, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 32'h0000_0400, 32'hFFFF_FFFC};
    vecs[13] = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[14] = '{ADD_W,        1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0000_0000, 32'h0000_0004};

    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'd0;
    clearVerdict();

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst pc", pc, RESET_PC);
    chk("rst inst", inst, 32'd0);
    chk("rst retired", retired, 32'd0);
    chk("rst req", {31'd0, imem_req}, 32'd0);
    chk("rst valid", {31'd0, inst_valid}, 32'd0);
    chk("rst trap", {31'd0, trap}, 32'd0);
    chk("rst pc_plus4", pc_plus4, 32'h0040_0004);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // one IDLE cycle, so the request is visible only now
    for (int i = 0; i < NVEC; i++) begin
      doStep(i);
    end

    // invalid opcode: halt, no more requests, retired frozen
    imem_ready = 1'b1;
    imem_rdata = 32'hFC00_0000;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    chk("inv valid", {31'd0, inst_valid}, 32'd1);
    chk("inv opc", {26'd0, opc}, 32'h0000_003F);
    inst_ack  = 1'b1;
    invOpcode = 1'b1;
    isJmp     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("inv trap", {31'd0, trap}, 32'd1);
    chk("inv req", {31'd0, imem_req}, 32'd0);
    chk("inv valid_after", {31'd0, inst_valid}, 32'd0);
    chk("inv retired", retired, 32'd15);
    chk("inv pc", pc, 32'h0000_0004);
    for (int k = 0; k < 4; k++) begin
      imem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("halt%0d trap", k), {31'd0, trap}, 32'd1);
      chk($sformatf("halt%0d req", k), {31'd0, imem_req}, 32'd0);
      chk($sformatf("halt%0d retired", k), retired, 32'd15);
    end
    imem_ready = 1'b0;
    clearVerdict();

    // reset out of HALT
    rst_n = 1'b0;
    #1;
    chk("halt_rst trap", {31'd0, trap}, 32'd0);
    chk("halt_rst pc", pc, RESET_PC);
    chk("halt_rst retired", retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    chk("refetch req", {31'd0, imem_req}, 32'd1);
    chk("refetch addr", imem_addr, RESET_PC);

    // reset in the middle of a FETCH wait
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst req", {31'd0, imem_req}, 32'd0);
    chk("midrst pc", pc, RESET_PC);
    // late ready during reset/IDLE must be ignored
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("late req", {31'd0, imem_req}, 32'd1);
    chk("late addr", imem_addr, RESET_PC);
    chk("late valid", {31'd0, inst_valid}, 32'd0);
    chk("late inst", inst, 32'd0);
    imem_rdata = ADD_W;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    chk("restart valid", {31'd0, inst_valid}, 32'd1);
    chk("restart inst", inst, ADD_W);
    chk("restart pc", pc, RESET_PC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
